// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes: a captured 128-bit state is run through InvSBox
// LANES bytes per cycle, with a valid/ready handshake on both sides.
module inv_sub_bytes #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_fsm;
    state_t             w_fsm_next;
    logic [127:0]       r_data;
    logic [CNT_W-1:0]   r_cnt;
    logic [LANES*8-1:0] w_grp_in;
    logic [LANES*8-1:0] w_grp_out;
    logic [127:0]       w_next_data;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hFE;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8];
        end
        return gf_inv(b ^ 8'h05);
    endfunction

    // Only LANES S-boxes exist; the active group is muxed in and written back.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_grp_in    = '0;
        w_next_data = r_data;
        for (int g = 0; g < GROUPS; g++) begin
            if (r_cnt == CNT_W'(g)) w_grp_in = r_data[g*LANES*8 +: LANES*8];
        end
        for (int j = 0; j < LANES; j++) begin
            w_grp_out[j*8 +: 8] = inv_sbox(w_grp_in[j*8 +: 8]);
        end
        for (int g = 0; g < GROUPS; g++) begin
            if (r_cnt == CNT_W'(g)) w_next_data[g*LANES*8 +: LANES*8] = w_grp_out;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid)      w_fsm_next = RUN;
            RUN:     if (r_cnt == LAST) w_fsm_next = DONE;
            DONE:    if (out_ready)     w_fsm_next = IDLE;
            default:                    w_fsm_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_fsm == IDLE);
        out_valid = (r_fsm == DONE);
        busy      = (r_fsm != IDLE);
    end

    // NOTE: the data register is reset because out_state must read zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_state;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_data <= w_next_data;
                    r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_state = r_data;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes: one instance per legal LANES value shares
// the stimulus; results are checked against the FIPS-197 inverse S-box table.
module tb_inv_sub_bytes;

    localparam int NI = 5;
    localparam int LN [NI] = '{1, 2, 4, 8, 16};

    localparam logic [7:0] INV_TBL [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_state;
    logic         w_in_ready  [NI];
    logic         w_out_valid [NI];
    logic         w_busy      [NI];
    logic [127:0] w_out_state [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            inv_sub_bytes #(.LANES(LN[g])) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (w_in_ready[g]),
                .in_state  (in_state),
                .out_valid (w_out_valid[g]),
                .out_ready (out_ready),
                .out_state (w_out_state[g]),
                .busy      (w_busy[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = INV_TBL[d[i*8 +: 8]];
        return r;
    endfunction

    task automatic check_ctrl(input string tag, input logic rdy, input logic vld, input logic bsy);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s in_ready L%0d", tag, LN[g]), w_in_ready[g], rdy);
            check($sformatf("%s out_valid L%0d", tag, LN[g]), w_out_valid[g], vld);
            check($sformatf("%s busy L%0d", tag, LN[g]), w_busy[g], bsy);
        end
    endtask

    // All instances must be idle on entry; they all accept on the same edge.
    task automatic send(input logic [127:0] d);
        in_state = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_ctrl("accept", 1'b0, 1'b0, 1'b1);
    endtask

    // Measures latency per instance, optionally stalls the output, then drains it.
    task automatic wait_result(input logic [127:0] exp, input int hold);
        int lat [NI];
        for (int g = 0; g < NI; g++) lat[g] = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) if (w_out_valid[g] && lat[g] == 0) lat[g] = c;
        end
        for (int g = 0; g < NI; g++) begin
            check($sformatf("latency L%0d", LN[g]), lat[g], 16 / LN[g]);
            check($sformatf("result L%0d", LN[g]), w_out_state[g], exp);
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            in_state = ~exp;
            repeat (hold) begin
                @(posedge clk); #1;
                check_ctrl("stall", 1'b0, 1'b1, 1'b1);
                for (int g = 0; g < NI; g++) check($sformatf("stall state L%0d", LN[g]), w_out_state[g], exp);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_ctrl("drain", 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < NI; g++) check($sformatf("held state L%0d", LN[g]), w_out_state[g], exp);
    endtask

    initial begin
        logic [127:0] d;
        logic         seen;
        int           last_acc [NI];
        logic [127:0] pend     [NI];

        // Reset with in_valid already high: nothing may be accepted until release.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_state  = {16{8'h63}};
        repeat (3) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < NI; g++) check($sformatf("reset state L%0d", LN[g]), w_out_state[g], 128'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_ctrl("first accept", 1'b0, 1'b0, 1'b1);
        wait_result(128'h0, 0);

        // Bytes 0x00..0x0F against the hand-copied first table row.
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
        send(d);
        wait_result(128'hfbd7f3819ea340bf38a53630d56a0952, 0);

        // All 256 byte values across 16 blocks, with table spot checks.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(k * 16 + i);
            send(d);
            wait_result(model(d), 0);
            for (int g = 0; g < NI; g++) begin
                case (k)
                    1:  check($sformatf("spot 16 L%0d", LN[g]), w_out_state[g][6*8 +: 8], 8'hff);
                    7:  check($sformatf("spot 7C L%0d", LN[g]), w_out_state[g][12*8 +: 8], 8'h01);
                    14: check($sformatf("spot ED L%0d", LN[g]), w_out_state[g][13*8 +: 8], 8'h53);
                    15: check($sformatf("spot FF L%0d", LN[g]), w_out_state[g][15*8 +: 8], 8'h7d);
                    default: ;
                endcase
            end
        end

        // Output held off for 10 cycles while a new input is offered.
        d = 128'h00112233445566778899aabbccddeeff;
        send(d);
        wait_result(model(d), 10);

        // Reset two RUN edges after accept: block must vanish without a result.
        send(128'h0123456789abcdeffedcba9876543210);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_ctrl("mid reset", 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < NI; g++) check($sformatf("mid reset state L%0d", LN[g]), w_out_state[g], 128'h0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            for (int g = 0; g < NI; g++) if (w_out_valid[g]) seen = 1'b1;
        end
        check("no valid after reset", seen, 1'b0);
        d = 128'hdeadbeefcafef00d1337c0de8badf00d;
        send(d);
        wait_result(model(d), 0);

        // Back-to-back traffic: accept spacing and in-order results.
        for (int g = 0; g < NI; g++) begin
            last_acc[g] = -1;
            pend[g]     = '0;
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_state = {16{c[7:0]}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (w_out_valid[g]) check($sformatf("stream result L%0d", LN[g]), w_out_state[g], pend[g]);
                if (w_in_ready[g]) begin
                    if (last_acc[g] >= 0) check($sformatf("spacing L%0d", LN[g]), c - last_acc[g], 16 / LN[g] + 2);
                    last_acc[g] = c;
                    pend[g]     = model(in_state);
                end
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
